// File: rtl/tone_player.sv
// Square-wave note player: plays one note (period, duration, volume) at a time
// on a single-bit speaker, with volume encoded as duty cycle.
module tone_player #(
   parameter int CNT_W    = 20,
   parameter int VOL_W    = 3,
   parameter int DUR_W    = 16,
   parameter int TICK_DIV = 100000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             note_valid,
   output logic             note_ready,
   input  logic [CNT_W-1:0] note_period,
   input  logic [DUR_W-1:0] note_dur,
   input  logic [VOL_W-1:0] vol,
   output logic             speaker,
   output logic             busy,
   output logic             note_done
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
   localparam logic [VOL_W:0]   VOL_FULL = {1'b1, {VOL_W{1'b0}}};

   typedef enum logic {IDLE, PLAY} state_t;

   state_t           state;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] phase;
   logic [CNT_W-1:0] t_on;
   logic [DUR_W-1:0] remaining;
   logic [PRE_W-1:0] prescale;

   logic             phase_wrap;
   logic             tick_wrap;
   logic             last_cycle;
   logic [CNT_W-1:0] next_phase;
   logic [CNT_W-1:0] next_ton;
   logic [CNT_W-1:0] accept_ton;

   // High time for one period: vol = max gives half the period, each step down halves it again.
   function automatic logic [CNT_W-1:0] calc_ton(input logic [CNT_W-1:0] p,
                                                 input logic [VOL_W-1:0] v);
      logic [VOL_W:0] sh;
      sh = VOL_FULL - {1'b0, v};
      if (v == '0) return '0;
      return p >> sh;
   endfunction

   assign note_ready = (state == IDLE);
   assign accept_ton = calc_ton(note_period, vol);
   assign phase_wrap = (period < CNT_W'(2)) || (phase == period - CNT_W'(1));
   assign next_phase = phase_wrap ? '0 : phase + CNT_W'(1);
   assign next_ton   = phase_wrap ? calc_ton(period, vol) : t_on;
   assign tick_wrap  = (prescale == PRE_MAX);
   assign last_cycle = tick_wrap && (remaining == DUR_W'(1));

   // Speaker is computed one cycle ahead, so the value shown always matches the current phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         period    <= '0;
         phase     <= '0;
         t_on      <= '0;
         remaining <= '0;
         prescale  <= '0;
         speaker   <= 1'b0;
         busy      <= 1'b0;
         note_done <= 1'b0;
      end else begin
         note_done <= 1'b0;
         case (state)
            IDLE: begin
               if (note_valid) begin
                  period    <= note_period;
                  remaining <= note_dur;
                  phase     <= '0;
                  prescale  <= '0;
                  if (note_dur != '0) begin
                     state   <= PLAY;
                     busy    <= 1'b1;
                     t_on    <= accept_ton;
                     speaker <= (accept_ton != '0);
                  end else begin
                     note_done <= 1'b1;
                  end
               end
            end
            PLAY: begin
               if (last_cycle) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  speaker   <= 1'b0;
                  note_done <= 1'b1;
                  phase     <= '0;
                  prescale  <= '0;
                  remaining <= '0;
                  t_on      <= '0;
               end else begin
                  phase    <= next_phase;
                  t_on     <= next_ton;
                  speaker  <= (next_ton != '0) && (next_phase < next_ton);
                  prescale <= tick_wrap ? '0 : prescale + PRE_W'(1);
                  if (tick_wrap) remaining <= remaining - DUR_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tone_player.sv
// Self-checking bench for tone_player: table of notes, hand-written corner
// sequences, and randomized notes checked against a cycle-indexed arithmetic model.
module tb_tone_player;

   localparam int CNT_W    = 20;
   localparam int VOL_W    = 3;
   localparam int DUR_W    = 16;
   localparam int TICK_DIV = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             note_valid;
   logic             note_ready;
   logic [CNT_W-1:0] note_period;
   logic [DUR_W-1:0] note_dur;
   logic [VOL_W-1:0] vol;
   logic             speaker;
   logic             busy;
   logic             note_done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          period;
      int          dur;
      int          vol;
      logic [31:0] expPattern;
   } vec_t;

   vec_t vecs[10];

   tone_player #(
      .CNT_W(CNT_W), .VOL_W(VOL_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)
   ) dut (
      .clk(clk), .reset(reset), .note_valid(note_valid), .note_ready(note_ready),
      .note_period(note_period), .note_dur(note_dur), .vol(vol),
      .speaker(speaker), .busy(busy), .note_done(note_done)
   );

   always #5 clk = ~clk;

   // High time of one period: half the period at max volume, halved per step below.
   function automatic int modelTon(input int p, input int v);
      if (v == 0) return 0;
      return p / (1 << ((1 << VOL_W) - v));
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Plays one note from acceptance to its note_done cycle; returns the speaker bits seen.
   task automatic applyStimulus(input int p, input int d, input int v, input int chgCycle,
                                input int chgVol, input bit randVol,
                                output logic [31:0] pattern);
      int hist[$];
      int len;
      int j0;
      int ton;
      int k;
      int expSp;
      len = d * TICK_DIV;
      pattern = '0;
      checkOutput("ready_before_accept", note_ready, 1);
      note_valid  = 1'b1;
      note_period = CNT_W'(p);
      note_dur    = DUR_W'(d);
      vol         = VOL_W'(v);
      hist.push_back(v);
      @(posedge clk);
      @(negedge clk);
      note_valid = 1'b0;
      for (int j = 1; j <= len; j++) begin
         expSp = 0;
         if (p >= 2) begin
            j0  = 1 + p * ((j - 1) / p);
            ton = modelTon(p, hist[j0-1]);
            k   = (j - 1) % p;
            expSp = (ton != 0 && k < ton) ? 1 : 0;
         end
         checkOutput("speaker", speaker, expSp);
         checkOutput("busy_in_play", busy, 1);
         checkOutput("ready_in_play", note_ready, 0);
         checkOutput("done_in_play", note_done, 0);
         pattern = {pattern[30:0], speaker};
         if (randVol) vol = VOL_W'($urandom_range(0, 7));
         else if (j == chgCycle) vol = VOL_W'(chgVol);
         hist.push_back(int'(vol));
         @(posedge clk);
         @(negedge clk);
      end
      checkOutput("note_done", note_done, 1);
      checkOutput("busy_after", busy, 0);
      checkOutput("speaker_gap", speaker, 0);
      checkOutput("ready_after", note_ready, 1);
   endtask

   task automatic idleCycle();
      @(posedge clk);
      @(negedge clk);
      checkOutput("done_single_pulse", note_done, 0);
      checkOutput("busy_idle", busy, 0);
      checkOutput("speaker_idle", speaker, 0);
   endtask

   initial begin
      logic [31:0] pat;
      int p, d, v;

      vecs[0] = '{8,  2, 7, 32'b11110000};
      vecs[1] = '{8,  2, 6, 32'b11000000};
      vecs[2] = '{8,  2, 1, 32'b00000000};
      vecs[3] = '{10, 3, 7, 32'b111110000011};
      vecs[4] = '{0,  1, 7, 32'b0000};
      vecs[5] = '{5,  0, 7, 32'b0};
      vecs[6] = '{2,  1, 7, 32'b1010};
      vecs[7] = '{1,  1, 7, 32'b0000};
      vecs[8] = '{8,  1, 0, 32'b0000};
      vecs[9] = '{16, 1, 5, 32'b1100};

      reset = 1'b1;
      note_valid = 1'b0;
      note_period = '0;
      note_dur = '0;
      vol = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("reset_speaker", speaker, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", note_done, 0);
      checkOutput("reset_ready", note_ready, 1);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].period, vecs[i].dur, vecs[i].vol, 0, 0, 1'b0, pat);
         checkOutput($sformatf("pattern_vec%0d", i), pat, vecs[i].expPattern);
         idleCycle();
      end

      // Volume change mid-period only affects the following period.
      applyStimulus(8, 4, 7, 4, 6, 1'b0, pat);
      checkOutput("pattern_vol_change", pat, 32'b1111000011000000);
      idleCycle();

      // Reset in the third play cycle of a long note, with a handshake held during reset.
      note_valid = 1'b1;
      note_period = CNT_W'(8);
      note_dur = DUR_W'(5);
      vol = VOL_W'(7);
      @(posedge clk);
      @(negedge clk);
      note_valid = 1'b0;
      for (int j = 1; j <= 3; j++) begin
         checkOutput("pre_reset_speaker", speaker, 1);
         checkOutput("pre_reset_busy", busy, 1);
         if (j < 3) begin
            @(posedge clk);
            @(negedge clk);
         end
      end
      reset = 1'b1;
      note_valid = 1'b1;
      note_dur = DUR_W'(1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("midreset_speaker", speaker, 0);
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_done", note_done, 0);
      reset = 1'b0;
      note_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("postreset_busy", busy, 0);
      checkOutput("postreset_done", note_done, 0);
      checkOutput("postreset_ready", note_ready, 1);
      applyStimulus(8, 2, 7, 0, 0, 1'b0, pat);
      checkOutput("pattern_after_reset", pat, 32'b11110000);

      // Back-to-back notes accepted in each note_done cycle.
      applyStimulus(4, 1, 7, 0, 0, 1'b0, pat);
      checkOutput("pattern_b2b_1", pat, 32'b1100);
      applyStimulus(0, 0, 7, 0, 0, 1'b0, pat);
      applyStimulus(8, 1, 6, 0, 0, 1'b0, pat);
      checkOutput("pattern_b2b_3", pat, 32'b1100);
      idleCycle();

      for (int n = 0; n < 25; n++) begin
         p = $urandom_range(0, 40);
         d = $urandom_range(0, 3);
         v = $urandom_range(0, 7);
         applyStimulus(p, d, v, 0, 0, 1'b1, pat);
         if ($urandom_range(0, 1) == 1) idleCycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
